share_arbiter: RTL and testbench
================================

# share_arbiter

Two-requester round-robin arbiter that sequences exclusive access to one shared datapath resource. It grants ownership to one requester at a time and bounds each tenure with a hold timer. It inserts one dead cycle between owners (break-before-make) and flags forced releases. It sits between the request-decode FSM and the shared channel, and drives the one-hot channel-enable bus.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles a grant may stay high; legal range 2..255.
- CNT_W, default $clog2(MAX_HOLD): hold-counter width; derived, never overridden.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clock clk.
- req  in  2  per-requester request level; bit i = requester i wants the resource.
- done  in  2  per-requester release strobe; only the current owner's bit is honoured.
- grant  out  2  registered one-hot grant; 2'b00 when no owner; never 2'b11.
- busy  out  1  registered; high exactly while grant != 0.
- owner  out  1  registered index of the last granted requester; the round-robin pointer.
- timeout  out  1  registered one-cycle pulse when a grant is removed by the hold limit.

## Operation
- States: S_IDLE, S_OWN, S_GAP.
- Reset values: state S_IDLE, grant 00, busy 0, owner 1 (requester 0 wins the first tie), timeout 0, counter 0.
- Arbitration is done in S_IDLE and S_GAP:
  - Only req[0] set: pick 0. Only req[1] set: pick 1.
  - Both set: pick !owner.
  - Neither set: no pick.
- S_IDLE: on a pick, go to S_OWN; grant[pick]=1, owner=pick, counter=0. Otherwise stay.
- S_OWN: release conditions, in priority order:
  - done[owner]=1: normal release.
  - req[owner]=0: request withdrawn, normal release.
  - counter==MAX_HOLD-1: forced release; timeout=1 for the next cycle.
  - On any release, go to S_GAP with grant=00. Otherwise counter+1 and hold.
- S_GAP: grant stays 00 for exactly one cycle. Arbitrate with the rule above: on a pick go to S_OWN, otherwise go to S_IDLE.
- Under contention, the timed-out owner loses to the other requester because the pointer has moved.
- done on the non-owner bit, and done outside S_OWN, are ignored.
- A done and a limit hit in the same cycle count as a normal release: no timeout pulse.
- Counter arithmetic is unsigned CNT_W bits. It never wraps because it is cleared on entry to S_OWN.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Grant latency: req sampled at edge k in S_IDLE/S_GAP → grant visible after edge k (1 cycle).
- Grant duration: minimum 1 cycle, maximum MAX_HOLD cycles.
- Release: done sampled at edge k → grant 00 after edge k.
- Owner-to-owner handoff: exactly one gap cycle with grant 00 between the two grants.
- timeout is high for exactly the first S_GAP cycle after a forced release.
- Reset asserted mid-tenure: grant, busy and timeout drop to 0 asynchronously, without waiting for a clock edge. The pointer returns to 1. The first edge after reset deassertion arbitrates from S_IDLE.

## Structure
- Shared package arb_pkg:
  - statetype enum {S_IDLE, S_OWN, S_GAP}, encoded as logic [1:0].
  - Requester-index constants REQ0=0 and REQ1=1.
- One sub-module, hold_timer:
  - Inputs: clk, reset, clear, enable.
  - Outputs: count, expired = (count==MAX_HOLD-1).
  - Parameterised by MAX_HOLD.
- The top level holds the FSM, the round-robin pointer and the output registers.

## Test plan
- Reset, then req=01 held with done=0, MAX_HOLD=4 → grant=01 for 4 cycles, then 00 with timeout=1 for 1 cycle, then grant=01 again; owner=0 throughout.
- Reset, then req=11 held, done=00 → grant sequence 01×4, 00, 10×4, 00, 01×4; timeout pulses at each 00.
- Owner 0 granted, done=01 pulsed in its 2nd grant cycle → grant 00 next cycle, no timeout; with req=10 pending, grant=10 one cycle later.
- Owner 1 granted, done=01 (non-owner) pulsed → ignored; grant stays 10 until the limit.
- done[owner]=1 on the cycle the counter reaches MAX_HOLD-1 → normal release, timeout stays 0.
- reset asserted between clock edges while grant=10 → grant=00, busy=0 immediately; after deassertion with req=11, the first grant is 01.

Source files
------------

// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg: shared state encoding and requester-index helpers for share_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN  = 2'd1,
      S_GAP  = 2'd2
   } statetype;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   function automatic logic [1:0] onehot2(input logic idx);
      logic [1:0] v;
      v = 2'b00;
      if (idx == REQ1) v[1] = 1'b1;
      else             v[0] = 1'b1;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/share_arbiter_hold_timer.sv
// ============================================================================
// hold_timer: tenure counter for share_arbiter; expired marks the last legal cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module hold_timer #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = $clog2(MAX_HOLD)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_count <= '0;
      else if (clear)  r_count <= '0;
      else if (enable) r_count <= r_count + 1'b1;
   end

   assign count   = r_count;
   assign expired = (r_count == CNT_W'(MAX_HOLD - 1));

endmodule

`default_nettype wire

// File: rtl/share_arbiter.sv
// ============================================================================
// share_arbiter: two-requester round-robin arbiter with hold limit and one dead
// cycle between owners. Rev 1.0
// ============================================================================
`default_nettype none

module share_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] done,
   output logic [1:0] grant,
   output logic       busy,
   output logic       owner,
   output logic       timeout
);

   localparam int CNT_W = $clog2(MAX_HOLD);

   statetype         r_state, w_next_state;
   logic [1:0]       r_grant, w_next_grant;
   logic             r_busy;
   logic             r_owner, w_next_owner;
   logic             r_timeout, w_next_timeout;
   logic             w_pick_valid, w_pick;
   logic             w_tmr_clear, w_tmr_enable, w_expired;
   logic [CNT_W-1:0] w_count;

   hold_timer #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) u_hold_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_tmr_clear),
      .enable  (w_tmr_enable),
      .count   (w_count),
      .expired (w_expired)
   );

   // Tie goes to the requester that did not own last, so the pointer alone decides fairness.
   assign w_pick_valid = |req;
   assign w_pick       = (req == 2'b11) ? ~r_owner : req[1];

   always_comb begin
      w_next_state   = r_state;
      w_next_grant   = r_grant;
      w_next_owner   = r_owner;
      w_next_timeout = 1'b0;
      w_tmr_clear    = 1'b0;
      w_tmr_enable   = 1'b0;
      case (r_state)
         S_IDLE, S_GAP: begin
            if (w_pick_valid) begin
               w_next_state = S_OWN;
               w_next_grant = onehot2(w_pick);
               w_next_owner = w_pick;
               w_tmr_clear  = 1'b1;
            end else begin
               w_next_state = S_IDLE;
               w_next_grant = 2'b00;
            end
         end
         S_OWN: begin
            // done/withdrawal outrank the limit, so a coincident hit is not a timeout.
            if (done[r_owner] || !req[r_owner]) begin
               w_next_state = S_GAP;
               w_next_grant = 2'b00;
            end else if (w_expired) begin
               w_next_state   = S_GAP;
               w_next_grant   = 2'b00;
               w_next_timeout = 1'b1;
            end else begin
               w_tmr_enable = 1'b1;
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_grant = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_grant   <= 2'b00;
         r_busy    <= 1'b0;
         r_owner   <= REQ1;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_grant   <= w_next_grant;
         r_busy    <= |w_next_grant;
         r_owner   <= w_next_owner;
         r_timeout <= w_next_timeout;
      end
   end

   assign grant   = r_grant;
   assign busy    = r_busy;
   assign owner   = r_owner;
   assign timeout = r_timeout;

   a_grant_onehot : assert property (@(posedge clk) disable iff (reset) r_grant != 2'b11);
   a_count_bound  : assert property (@(posedge clk) disable iff (reset)
                                     (r_state != S_OWN) || (w_count <= CNT_W'(MAX_HOLD - 1)));

endmodule

`default_nettype wire

// File: tb/tb_share_arbiter.sv
// ============================================================================
// tb_share_arbiter: directed self-checking bench for share_arbiter (MAX_HOLD=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_share_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] req;
   logic [1:0] done;
   logic [1:0] grant;
   logic       busy;
   logic       owner;
   logic       timeout;

   int checks;
   int errors;

   share_arbiter #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .busy    (busy),
      .owner   (owner),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = 2'b00;
      done  = 2'b00;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner got %b want 1", owner); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
   endtask

   task automatic test_single_timeout();
      do_reset();
      req = 2'b01;
      for (int i = 0; i < 6; i++) begin
         logic [1:0] eg;
         logic       et;
         eg = (i == 4) ? 2'b00 : 2'b01;
         et = (i == 4);
         tick();
         checks++; if (grant !== eg) begin errors++; $display("FAIL single_grant[%0d] got %b want %b", i, grant, eg); end
         checks++; if (timeout !== et) begin errors++; $display("FAIL single_timeout[%0d] got %b want %b", i, timeout, et); end
         checks++; if (busy !== (eg != 2'b00)) begin errors++; $display("FAIL single_busy[%0d] got %b", i, busy); end
         checks++; if (owner !== 1'b0) begin errors++; $display("FAIL single_owner[%0d] got %b want 0", i, owner); end
      end
   endtask

   task automatic test_contention();
      do_reset();
      req = 2'b11;
      for (int i = 0; i < 14; i++) begin
         logic [1:0] eg;
         logic       et;
         et = ((i % 5) == 4);
         eg = et ? 2'b00 : (((i / 5) % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         checks++; if (grant !== eg) begin errors++; $display("FAIL contend_grant[%0d] got %b want %b", i, grant, eg); end
         checks++; if (timeout !== et) begin errors++; $display("FAIL contend_timeout[%0d] got %b want %b", i, timeout, et); end
      end
   endtask

   task automatic test_done_release();
      do_reset();
      req = 2'b11;
      tick();
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL done_first got %b want 01", grant); end
      tick();
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL done_second got %b want 01", grant); end
      done = 2'b01;
      tick();
      done = 2'b00;
      req  = 2'b10;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL done_gap got %b want 00", grant); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL done_no_timeout got %b want 0", timeout); end
      tick();
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL done_handoff got %b want 10", grant); end
      checks++; if (owner !== 1'b1) begin errors++; $display("FAIL done_owner got %b want 1", owner); end
   endtask

   task automatic test_nonowner_done();
      do_reset();
      req = 2'b10;
      tick();
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL nonown_first got %b want 10", grant); end
      done = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (grant !== 2'b10) begin errors++; $display("FAIL nonown_hold[%0d] got %b want 10", i, grant); end
      end
      tick();
      done = 2'b00;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL nonown_limit got %b want 00", grant); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL nonown_timeout got %b want 1", timeout); end
   endtask

   task automatic test_done_at_limit();
      do_reset();
      req = 2'b01;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL limit_last got %b want 01", grant); end
      done = 2'b01;
      tick();
      done = 2'b00;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL limit_release got %b want 00", grant); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL limit_timeout got %b want 0", timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL limit_busy got %b want 0", busy); end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 2'b10;
      tick();
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL areset_pre got %b want 10", grant); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL areset_grant got %b want 00", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
      checks++; if (owner !== 1'b1) begin errors++; $display("FAIL areset_owner got %b want 1", owner); end
      req = 2'b11;
      tick();
      reset = 1'b0;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL areset_hold got %b want 00", grant); end
      tick();
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL areset_first got %b want 01", grant); end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL areset_owner0 got %b want 0", owner); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      req    = 2'b00;
      done   = 2'b00;
      test_reset();
      test_single_timeout();
      test_contention();
      test_done_release();
      test_nonowner_done();
      test_done_at_limit();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
